// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types for the register file slice.
package mips_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_COUNT      = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

  typedef logic [WORD_WIDTH-1:0]     word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/register_word.sv
// One general-purpose register word: synchronous clear, enable-gated load.
module register_word #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] r_data;

  // Clear beats load; without enable the word holds.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_data <= '0;
    end else if (enable) begin
      r_data <= data_in;
    end
  end

  assign data_out = r_data;

endmodule

// File: rtl/register_file.sv
// MIPS register file: 2 combinational read ports, 1 synchronous write port.
// r0 is hardwired to zero and has no storage.
// Optional build macro REGFILE_BYPASS_EN adds same-cycle write-through
// forwarding onto each read port; without it, same-cycle reads see the
// old stored value.
module register_file
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_regs;
  logic [NUM_REGS-1:1]                 w_enable;

  assign w_regs[0] = '0;

  // Write decoder: one-hot word enable; entry 0 never gets one.
  always_comb begin
    w_enable = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_enable[i] = write_enable && (write_addr == ADDR_WIDTH'(i));
    end
  end

  // Storage for r1..r(N-1); write data is broadcast, enable selects the word.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_word
    register_word #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_word (
      .clock    (clock),
      .clear    (clear),
      .enable   (w_enable[g]),
      .data_in  (write_data),
      .data_out (w_regs[g])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic w_fwd_valid;

  // A write that will really commit this edge is eligible for forwarding.
  assign w_fwd_valid = write_enable && !clear &&
                       (write_addr != ADDR_WIDTH'(ZERO_REG));

  // Read muxes with per-port write-through forwarding.
  always_comb begin
    read_data_a = w_regs[read_addr_a];
    read_data_b = w_regs[read_addr_b];
    if (w_fwd_valid && (write_addr == read_addr_a)) begin
      read_data_a = write_data;
    end
    if (w_fwd_valid && (write_addr == read_addr_b)) begin
      read_data_b = write_data;
    end
  end
`else
  // Read muxes straight from stored state.
  always_comb begin
    read_data_a = w_regs[read_addr_a];
    read_data_b = w_regs[read_addr_b];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
  import mips_pkg::*;

  logic      clock;
  logic      clear;
  reg_addr_t read_addr_a;
  reg_addr_t read_addr_b;
  word_t     read_data_a;
  word_t     read_data_b;
  logic      write_enable;
  reg_addr_t write_addr;
  word_t     write_data;

  int    n_checks;
  int    n_pass;
  word_t model [REG_COUNT];

  register_file dut (
    .clock        (clock),
    .clear        (clear),
    .read_addr_a  (read_addr_a),
    .read_addr_b  (read_addr_b),
    .read_data_a  (read_data_a),
    .read_data_b  (read_data_b),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs may change afterwards.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input reg_addr_t a, input word_t d);
    write_enable = 1'b1;
    write_addr   = a;
    write_data   = d;
    tick();
    write_enable = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
  endtask

  // Read every address on both ports (B walks in reverse) against the model.
  task automatic scan_all(input string tag);
    for (int i = 0; i < REG_COUNT; i++) begin
      read_addr_a = reg_addr_t'(i);
      read_addr_b = reg_addr_t'(REG_COUNT - 1 - i);
      #1;
      check_eq($sformatf("%s_a_r%0d", tag, i), read_data_a, model[i]);
      check_eq($sformatf("%s_b_r%0d", tag, REG_COUNT - 1 - i), read_data_b,
               model[REG_COUNT - 1 - i]);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    clear        = 1'b0;
    write_enable = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    read_addr_a  = '0;
    read_addr_b  = '0;
    clear_model();

    // Reset: one clearing edge, everything reads zero.
    #2;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    scan_all("reset");

    // Basic write to r5, neighbours untouched.
    do_write(5'd5, 32'hDEADBEEF);
    read_addr_a = 5'd5; read_addr_b = 5'd5; #1;
    check_eq("r5_a", read_data_a, 32'hDEADBEEF);
    check_eq("r5_b", read_data_b, 32'hDEADBEEF);
    read_addr_a = 5'd4; read_addr_b = 5'd6; #1;
    check_eq("r4_zero", read_data_a, 32'h0);
    check_eq("r6_zero", read_data_b, 32'h0);

    // Writes to r0 are dropped.
    do_write(5'd0, 32'hFFFFFFFF);
    read_addr_a = 5'd0; read_addr_b = 5'd0; #1;
    check_eq("r0_a", read_data_a, 32'h0);
    check_eq("r0_b", read_data_b, 32'h0);
    scan_all("after_r0");

    // Same-cycle write and read of r9.
    do_write(5'd9, 32'hAAAA0000);
    write_enable = 1'b1;
    write_addr   = 5'd9;
    write_data   = 32'h12345678;
    read_addr_a  = 5'd9;
    read_addr_b  = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("r9_same_cycle", read_data_a, 32'h12345678);
`else
    check_eq("r9_same_cycle", read_data_a, 32'hAAAA0000);
`endif
    check_eq("r5_other_port", read_data_b, 32'hDEADBEEF);
    tick();
    write_enable = 1'b0;
    model[9] = 32'h12345678;
    #1;
    check_eq("r9_next_cycle", read_data_a, 32'h12345678);

    // Clear beats a simultaneous write; no forwarding while clearing.
    do_write(5'd7, 32'h00000011);
    clear        = 1'b1;
    write_enable = 1'b1;
    write_addr   = 5'd7;
    write_data   = 32'h00000055;
    read_addr_a  = 5'd7;
    read_addr_b  = 5'd9;
    #1;
    check_eq("r7_during_clear", read_data_a, 32'h00000011);
    check_eq("r9_during_clear", read_data_b, 32'h12345678);
    tick();
    clear        = 1'b0;
    write_enable = 1'b0;
    clear_model();
    #1;
    check_eq("r7_after_clear", read_data_a, 32'h0);
    check_eq("r9_after_clear", read_data_b, 32'h0);
    scan_all("after_clear");

    // Extreme values at the top and bottom addresses, then hold.
    do_write(5'd31, 32'h80000001);
    do_write(5'd1,  32'h7FFFFFFF);
    read_addr_a = 5'd31; read_addr_b = 5'd1; #1;
    check_eq("r31", read_data_a, 32'h80000001);
    check_eq("r1",  read_data_b, 32'h7FFFFFFF);
    for (int c = 0; c < 3; c++) begin
      write_enable = 1'b0;
      write_addr   = reg_addr_t'($urandom_range(1, 31));
      write_data   = $urandom();
      tick();
      check_eq($sformatf("hold_r31_c%0d", c), read_data_a, 32'h80000001);
      check_eq($sformatf("hold_r1_c%0d", c),  read_data_b, 32'h7FFFFFFF);
    end
    scan_all("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
